mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Sequential accumulator directly downstream of the combinational array multiplier: it consumes one `(N+M)`-bit unsigned product per valid/ready handshake. It sums `COUNT` consecutive products into a saturating `ACC_W`-bit accumulator and presents the total on a registered output channel. It turns the multiplier into a multiply-accumulate path for dot-product style use.

## Interface
- `N`, default 3: width of multiplier operand A; product width is `N+M`.
- `M`, default 4: width of multiplier operand B.
- `COUNT`, default 4: products summed per result; legal range is 1 or more.
- `ACC_W`, default 8: accumulator and result width; legal range is `ACC_W >= N+M`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous abort of the current accumulation.
- `in_valid` in 1: `product` is valid.
- `in_ready` out 1: block accepts a product this cycle.
- `product` in `N+M`: unsigned product from the multiplier.
- `out_valid` out 1: `acc_out` holds a completed result.
- `out_ready` in 1: the consumer takes the result this cycle.
- `acc_out` out `ACC_W`: completed sum, registered.
- `sat` out 1: `acc_out` was clamped; valid while `out_valid` is high.

## Operation
- Two states: `ACCUM` and `HOLD`.
- `in_ready = (state == ACCUM)`. `out_valid = (state == HOLD)`.
- **ACCUM state:**
  - A beat is accepted when `in_valid && in_ready`.
  - On an accepted beat: `acc <= sat_add(acc, zero-extended product)` and `cnt <= cnt + 1`.
  - On the beat where `cnt == COUNT-1`:
    - `acc_out` gets the final saturated sum, including this beat.
    - `sat` is the OR of all saturation events in this group.
    - `acc` and `cnt` clear to 0 and the sticky saturation flag clears.
    - State moves to `HOLD`.
- **HOLD state:** no input is accepted. On `out_ready`, the state returns to `ACCUM`. `acc_out` and `sat` keep their values until the next result is written.
- **Saturating add:** compute at `ACC_W+1` bits. If bit `ACC_W` is set, the result is `{ACC_W{1'b1}}` and the sticky saturation flag is set. Once saturated, the sum stays at max for the rest of the group.
- **`clear`:** highest priority, wins over any same-cycle handshake.
  - `acc`, `cnt` and the sticky flag go to 0; state goes to `ACCUM`.
  - A result in `HOLD` is discarded, so `out_valid` drops the next cycle.
  - A beat presented in the same cycle is not accepted, even though `in_ready` is high.
- `COUNT == 1`: every accepted beat produces a result. `cnt` is a constant 0.

## Timing
- **Reset values:** state `ACCUM`, so `in_ready = 1` combinationally, including while `rst_n` is low. `out_valid = 0`, `acc_out = 0`, `sat = 0`, internal `acc = 0`, `cnt = 0`.
- **Latency:** `out_valid` rises on the clock edge that accepts the `COUNT`-th beat. With back-to-back input, results appear every `COUNT+1` cycles at best; the extra cycle is the `HOLD` cycle in which `out_ready` is sampled.
- **Handshakes:**
  - `in_ready` and `out_valid` depend on state only; there is no combinational path from `in_valid` or `out_ready`.
  - `acc_out` is stable while `out_valid && !out_ready`.
  - The upstream block must hold `product` stable while `in_valid && !in_ready`.
- `rst_n` asserted mid-group: all state is cleared immediately; the partial sum is lost.

## Structure
- Package `mac_pkg` holds:
  - the state typedef `mac_state_t { ACCUM, HOLD }`;
  - `CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1`, provided as a function of `COUNT`.
- Sub-module `sat_add #(IN_W, ACC_W)` is combinational. It takes `a[ACC_W]` and `b[IN_W]` and returns `sum[ACC_W]` and `ovf`.
- Top level holds the FSM, the `cnt`/`acc`/sticky registers, and the output registers.

## Test plan
- **Basic group:** defaults, reset, products 6, 10, 20, 30 back-to-back with `out_ready = 1` -> `out_valid` for one cycle after the 4th beat, `acc_out = 66`, `sat = 0`, `in_ready` low for exactly that cycle.
- **Saturation:** four products of 105 (7×15) -> `acc_out = 255`, `sat = 1`. The next group 1, 1, 1, 1 -> `acc_out = 4`, `sat = 0`.
- **Backpressure:** complete a group of sum 40 and hold `out_ready = 0` for 5 cycles while driving `in_valid = 1` -> `acc_out` stays 40, `in_ready = 0`, no beat is consumed. Raising `out_ready` -> the next group starts from 0.
- **Clear:**
  - After 2 beats (sum 15), assert `clear` together with a valid beat of 9; then send 4 beats of 1 -> `acc_out = 4`.
  - `clear` asserted in `HOLD` -> `out_valid` drops, no handshake occurs.
- **Async reset mid-group:** after 3 beats, pulse `rst_n` low between edges -> outputs return to their reset values immediately. The following group of 2, 2, 2, 2 yields 8.
- **Parameter corner:** `COUNT = 1`, `ACC_W = 7` -> product 100 gives `acc_out = 100`, `sat = 0`; max product 105 gives 105. Each beat is followed by one `HOLD` cycle.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the multiply-accumulate path.
// Holds the accumulator FSM state type and the counter width function.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_t;

  function automatic int cnt_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/mac_accumulator_sat_add.sv
// Combinational saturating adder: unsigned a + zero-extended b,
// clamped to all-ones when the carry out of ACC_W bits is set.
module sat_add #(
  parameter int IN_W  = 7,
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  always_comb begin
    full = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
    ovf  = full[ACC_W];
    sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sums COUNT multiplier products into a saturating accumulator and
// presents each total on a registered valid/ready output channel.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N     = 3,
  parameter int M     = 4,
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N+M-1:0]   product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat
);

  localparam int P_W   = N + M;
  localparam int CNT_W = cnt_w(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  mac_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stk_q, stk_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             sat_q, sat_d;

  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic             last;

  sat_add #(
    .IN_W  (P_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (product),
    .sum (sum),
    .ovf (ovf)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign acc_out   = out_q;
  assign sat       = sat_q;
  assign last      = (COUNT == 1) || (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    stk_d   = stk_q;
    out_d   = out_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      stk_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (last) begin
              out_d   = sum;
              sat_d   = stk_q | ovf;
              acc_d   = '0;
              cnt_d   = '0;
              stk_d   = 1'b0;
              state_d = HOLD;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_W'(1);
              stk_d = stk_q | ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      stk_q   <= 1'b0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      stk_q   <= stk_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: default build plus a
// COUNT=1, ACC_W=7 instance for the parameter corner.
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] product;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc_out;
  logic       sat;

  logic       v2, r2, ov2, or2, s2;
  logic [6:0] p2;
  logic [6:0] a2;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] acc;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .sat       (sat)
  );

  mac_accumulator #(
    .N(3), .M(4), .COUNT(1), .ACC_W(7)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (1'b0),
    .in_valid  (v2),
    .in_ready  (r2),
    .product   (p2),
    .out_valid (ov2),
    .out_ready (or2),
    .acc_out   (a2),
    .sat       (s2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(acc_out), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("acc_out", int'(acc_out), int'(e.acc));
        chk("sat", int'(sat), int'(e.sat));
      end
    end
  end

  task automatic send(input logic [6:0] p);
    int n;
    n = 0;
    in_valid = 1'b1;
    product  = p;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [6:0] p, input int exp);
    int n;
    n = 0;
    v2 = 1'b1;
    p2 = p;
    @(negedge clk);
    while (!r2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send1_timeout", n, 0);
    tick();
    v2 = 1'b0;
    chk("c1_out_valid", int'(ov2), 1);
    chk("c1_in_ready", int'(r2), 0);
    chk("c1_acc_out", int'(a2), exp);
    chk("c1_sat", int'(s2), 0);
    tick();
    chk("c1_hold_one_cycle", int'(ov2), 0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; product = '0;
    out_ready = 1'b1;
    v2 = 1'b0; p2 = '0; or2 = 1'b1;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_acc_out", int'(acc_out), 0);
    chk("rst_sat", int'(sat), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Basic group
    exp_q.push_back('{acc: 8'd66, sat: 1'b0});
    send4(6, 10, 20, 30);
    chk("basic_out_valid", int'(out_valid), 1);
    chk("basic_in_ready_low", int'(in_ready), 0);
    tick();
    chk("basic_valid_drop", int'(out_valid), 0);
    chk("basic_in_ready_back", int'(in_ready), 1);

    // Saturation, then a clean group
    exp_q.push_back('{acc: 8'd255, sat: 1'b1});
    send4(105, 105, 105, 105);
    exp_q.push_back('{acc: 8'd4, sat: 1'b0});
    send4(1, 1, 1, 1);
    tick();

    // Backpressure
    out_ready = 1'b0;
    exp_q.push_back('{acc: 8'd40, sat: 1'b0});
    send4(10, 10, 10, 10);
    in_valid = 1'b1;
    product  = 7'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_acc_out", int'(acc_out), 40);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_q.push_back('{acc: 8'd4, sat: 1'b0});
    send4(1, 1, 1, 1);
    tick();

    // Clear with a same-cycle beat mid-group
    send(10);
    send(5);
    clear    = 1'b1;
    in_valid = 1'b1;
    product  = 7'd9;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    exp_q.push_back('{acc: 8'd4, sat: 1'b0});
    send4(1, 1, 1, 1);
    tick();

    // Clear while a result is held
    out_ready = 1'b0;
    send4(3, 3, 3, 3);
    chk("clr_hold_valid", int'(out_valid), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_hold_drop", int'(out_valid), 0);
    chk("clr_hold_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    exp_q.push_back('{acc: 8'd20, sat: 1'b0});
    send4(5, 5, 5, 5);
    tick();

    // Async reset mid-group
    send(50);
    send(50);
    send(50);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_acc_out", int'(acc_out), 0);
    chk("arst_sat", int'(sat), 0);
    #1 rst_n = 1'b1;
    tick();
    exp_q.push_back('{acc: 8'd8, sat: 1'b0});
    send4(2, 2, 2, 2);
    tick();

    // COUNT = 1, ACC_W = 7
    send1(7'd100, 100);
    send1(7'd105, 105);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
